// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment display driver.
//   state_t   : controller states (idle, running a scan, fault latched)
//   RING_FIRST: ring value that marks digit 0, i.e. the start of a frame
//   SEG_GLYPH : hex glyph table, bit order {g,f,e,d,c,b,a}, active-high
//   rotl1     : one-step left rotation of a 4-bit ring value
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0] RING_FIRST = 4'b0001;

    // Glyphs for 0-9, A, b, C, d, E, F
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [3:0] rotl1(input logic [3:0] value);
        return {value[2:0], value[3]};
    endfunction

endpackage

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// Purely combinational hex-to-seven-segment decoder.
//   i_nibble : 4-bit hex digit
//   o_seg    : segments {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/seg_mux.sv
// ---------------------------------------------------------------------------
// seg_mux
// Drives a 4-digit multiplexed seven-segment display from an external
// one-hot ring counter. Data is double buffered (pending -> shadow) and the
// shadow only changes at a frame start so a frame never shows mixed data.
// A ring sequence that is neither a hold nor a single left rotation latches
// a fault that blanks the display until acknowledged with clear.
//   clk, reset   : clock, synchronous active-high reset
//   ring_in      : one-hot digit select from the ring counter
//   data_in      : four hex digits, digit k in data_in[4k+3:4k]
//   load         : capture data_in (pulse)
//   clear        : fault acknowledge (pulse)
//   an, seg      : registered digit enable / segments, active-high
//   load_pending : captured data is waiting for the next frame start
//   fault        : controller is in the fault state
//   frame_cnt    : number of frame starts seen while running (wraps)
// ---------------------------------------------------------------------------
module seg_mux
    import seg_pkg::*;
#(
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         ring_in,
    input  logic [15:0]        data_in,
    input  logic               load,
    input  logic               clear,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               load_pending,
    output logic               fault,
    output logic [FRAME_W-1:0] frame_cnt
);

    state_t             r_state;
    state_t             w_stateNext;
    logic [3:0]         r_prevRing;
    logic [15:0]        r_shadow;
    logic [15:0]        r_pending;
    logic               r_loadPending;
    logic [FRAME_W-1:0] r_frameCnt;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_ringLegal;
    logic               w_frameStart;
    logic               w_countFrame;
    logic [15:0]        w_shadowNext;
    logic [15:0]        w_pendingNext;
    logic               w_loadPendingNext;
    logic [3:0]         w_digit;
    logic [6:0]         w_glyph;

    // While running, r_prevRing is always one-hot (we only stay in RUN on a
    // legal value and enter from IDLE with 0001), so hold-or-rotate is the
    // complete legality test; zero and multi-hot values fail both compares.
    assign w_ringLegal = (ring_in == r_prevRing) || (ring_in == rotl1(r_prevRing));

    // Next-state logic. A frame start is the IDLE->RUN entry or a fresh
    // 0001 in RUN; only the latter advances the frame counter, and a held
    // 0001 is not fresh.
    always_comb begin
        w_stateNext  = r_state;
        w_frameStart = 1'b0;
        w_countFrame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ring_in == RING_FIRST) begin
                    w_stateNext  = ST_RUN;
                    w_frameStart = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_ringLegal) begin
                    w_stateNext = ST_FAULT;
                end else if ((ring_in == RING_FIRST) && (r_prevRing != RING_FIRST)) begin
                    w_frameStart = 1'b1;
                    w_countFrame = 1'b1;
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Double buffering. A load that lands on a frame start goes straight to
    // the shadow and leaves nothing pending; otherwise it (re)fills pending,
    // which is promoted at the next frame start.
    always_comb begin
        w_shadowNext      = r_shadow;
        w_pendingNext     = r_pending;
        w_loadPendingNext = r_loadPending;
        if (w_frameStart) begin
            if (load) begin
                w_shadowNext = data_in;
            end else if (r_loadPending) begin
                w_shadowNext = r_pending;
            end
            w_loadPendingNext = 1'b0;
        end else if (load) begin
            w_pendingNext     = data_in;
            w_loadPendingNext = 1'b1;
        end
    end

    // Digit select uses the post-update shadow so new data appears together
    // with digit 0 on the frame-start edge.
    always_comb begin
        w_digit = 4'h0;
        case (ring_in)
            4'b0001: w_digit = w_shadowNext[3:0];
            4'b0010: w_digit = w_shadowNext[7:4];
            4'b0100: w_digit = w_shadowNext[11:8];
            4'b1000: w_digit = w_shadowNext[15:12];
            default: w_digit = 4'h0;
        endcase
    end

    hex7seg u_hex7seg (
        .i_nibble (w_digit),
        .o_seg    (w_glyph)
    );

    // State and output registers. Display outputs follow the state being
    // entered, so they blank on the same edge that enters FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_prevRing    <= 4'b0000;
            r_shadow      <= 16'h0000;
            r_pending     <= 16'h0000;
            r_loadPending <= 1'b0;
            r_frameCnt    <= '0;
            r_an          <= 4'b0000;
            r_seg         <= 7'b0000000;
        end else begin
            r_state       <= w_stateNext;
            r_prevRing    <= ring_in;
            r_shadow      <= w_shadowNext;
            r_pending     <= w_pendingNext;
            r_loadPending <= w_loadPendingNext;
            if (w_countFrame) begin
                r_frameCnt <= r_frameCnt + FRAME_W'(1);
            end
            if (w_stateNext == ST_RUN) begin
                r_an  <= ring_in;
                r_seg <= w_glyph;
            end else begin
                r_an  <= 4'b0000;
                r_seg <= 7'b0000000;
            end
        end
    end

    assign an           = r_an;
    assign seg          = r_seg;
    assign load_pending = r_loadPending;
    assign fault        = (r_state == ST_FAULT);
    assign frame_cnt    = r_frameCnt;

endmodule

// File: tb/tb_seg_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_mux
// Scoreboard bench for seg_mux. Two instances (FRAME_W=8 and FRAME_W=2)
// share the same stimulus. Each cycle the driver advances a behavioural
// model that tracks the display in terms of digit positions and frame
// events, and queues the expected outputs; a monitor pops and compares on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_seg_mux;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       lp;
        logic       flt;
        int         cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  ring;
    logic [15:0] data;
    logic        ld;
    logic        clr;

    logic [3:0]  an8, an2;
    logic [6:0]  seg8, seg2;
    logic        lp8, lp2;
    logic        flt8, flt2;
    logic [7:0]  cnt8;
    logic [1:0]  cnt2;

    exp_t        expQ [$];
    int          checks;
    int          errors;

    int          mMode;
    logic [3:0]  mPrev;
    logic [15:0] mShadow;
    logic [15:0] mPending;
    bit          mHas;
    int          mCount;
    int          ringPos;

    seg_mux #(.FRAME_W(8)) dut8 (
        .clk          (clk),
        .reset        (rst),
        .ring_in      (ring),
        .data_in      (data),
        .load         (ld),
        .clear        (clr),
        .an           (an8),
        .seg          (seg8),
        .load_pending (lp8),
        .fault        (flt8),
        .frame_cnt    (cnt8)
    );

    seg_mux #(.FRAME_W(2)) dut2 (
        .clk          (clk),
        .reset        (rst),
        .ring_in      (ring),
        .data_in      (data),
        .load         (ld),
        .clear        (clr),
        .an           (an2),
        .seg          (seg2),
        .load_pending (lp2),
        .fault        (flt2),
        .frame_cnt    (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ringIdx(input logic [3:0] r);
        case (r)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Reference behaviour for one rising edge, using the inputs just sampled.
    task automatic modelStep();
        exp_t e;
        int   pi;
        int   ri;
        int   nextMode;
        bit   start;
        bit   runStart;
        if (rst) begin
            mMode    = M_IDLE;
            mPrev    = 4'b0000;
            mShadow  = 16'h0000;
            mPending = 16'h0000;
            mHas     = 1'b0;
            mCount   = 0;
        end else begin
            pi       = ringIdx(mPrev);
            ri       = ringIdx(ring);
            nextMode = mMode;
            start    = 1'b0;
            runStart = 1'b0;
            if (mMode == M_IDLE) begin
                if (ri == 0) begin
                    nextMode = M_RUN;
                    start    = 1'b1;
                end
            end else if (mMode == M_RUN) begin
                if (ri >= 0 && (ri == pi || ri == (pi + 1) % 4)) begin
                    if (ri == 0 && pi != 0) begin
                        start    = 1'b1;
                        runStart = 1'b1;
                    end
                end else begin
                    nextMode = M_FAULT;
                end
            end else begin
                if (clr) nextMode = M_IDLE;
            end
            if (start) begin
                if (ld) mShadow = data;
                else if (mHas) mShadow = mPending;
                mHas = 1'b0;
            end else if (ld) begin
                mPending = data;
                mHas     = 1'b1;
            end
            if (runStart) mCount++;
            mPrev = ring;
            mMode = nextMode;
        end
        e.lp  = mHas;
        e.flt = (mMode == M_FAULT);
        e.cnt = mCount;
        if (mMode == M_RUN) begin
            ri    = ringIdx(ring);
            e.an  = ring;
            e.seg = GLYPH[mShadow[4*ri +: 4]];
        end else begin
            e.an  = 4'b0000;
            e.seg = 7'b0000000;
        end
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs, let the DUT sample them, queue the result.
    task automatic applyStimulus(input bit r, input bit l, input bit c,
                                 input logic [3:0] rg, input logic [15:0] d);
        rst  = r;
        ld   = l;
        clr  = c;
        ring = rg;
        data = d;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic cleanRing(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001 << ringPos, 16'h0000);
            ringPos = (ringPos + 1) % 4;
        end
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("an",           int'(an8),  int'(e.an));
        cmp("seg",          int'(seg8), int'(e.seg));
        cmp("load_pending", int'(lp8),  int'(e.lp));
        cmp("fault",        int'(flt8), int'(e.flt));
        cmp("frame_cnt8",   int'(cnt8), e.cnt % 256);
        cmp("an_w2",        int'(an2),  int'(e.an));
        cmp("seg_w2",       int'(seg2), int'(e.seg));
        cmp("lp_w2",        int'(lp2),  int'(e.lp));
        cmp("fault_w2",     int'(flt2), int'(e.flt));
        cmp("frame_cnt2",   int'(cnt2), e.cnt % 4);
    endtask

    // Monitor: compare whatever the DUT presents after each rising edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Stimulus sequence: directed scenarios followed by randomized traffic.
    initial begin
        logic [3:0] ringCur;
        int         roll;
        checks  = 0;
        errors  = 0;
        ringPos = 0;
        mMode   = M_IDLE;
        mPrev   = 4'b0000;
        mShadow = 16'h0000;
        mPending = 16'h0000;
        mHas    = 1'b0;
        mCount  = 0;

        // Reset for 15 ns, then load 1234 while idle and run clean frames
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 16'h1234);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000);
        cleanRing(12);

        // Mid-frame load must wait for the next digit-0 edge
        cleanRing(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100, 16'hABCD);
        ringPos = 3;
        cleanRing(5);

        // Multi-hot ring -> fault; clean ring ignored; clear; resume
        cleanRing(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101, 16'h0000);
        ringPos = 3;
        cleanRing(10);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000);
        ringPos = 0;
        cleanRing(8);

        // Out-of-order ring -> fault; then a held 0010 is legal
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000);
        ringPos = 0;
        cleanRing(2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 16'h0000);
        end
        ringPos = 2;
        cleanRing(10);

        // Long clean run with sporadic loads; wraps both frame counters
        ringPos = 0;
        for (int i = 0; i < 1200; i++) begin
            applyStimulus(1'b0, ($urandom % 8) == 0, 1'b0,
                          4'b0001 << ringPos, 16'($urandom));
            ringPos = (ringPos + 1) % 4;
        end

        // Randomized traffic including illegal rings, clears and resets
        ringCur = 4'b0001;
        for (int i = 0; i < 2000; i++) begin
            roll = int'($urandom % 100);
            if (roll < 10) begin
                ringCur = 4'($urandom);
            end else begin
                if ($countones(ringCur) != 1) ringCur = 4'b0001;
                else if (roll < 75) ringCur = {ringCur[2:0], ringCur[3]};
            end
            applyStimulus(($urandom % 150) == 0, ($urandom % 7) == 0,
                          ($urandom % 10) == 0, ringCur, 16'($urandom));
        end

        // Reset mid-frame with load asserted and data pending
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000);
        ringPos = 0;
        cleanRing(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100, 16'h5678);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b1000, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000);
        ringPos = 0;
        cleanRing(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000);

        @(negedge clk);
        #1;
        cmp("scoreboard_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
